// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with per-channel debounced up/down buttons,
// shadow duty registers loaded at the period boundary, and edge/centre-aligned output modes.
module pwm_multi_ch #(
    parameter int CHANNELS  = 2,
    parameter int CNT_W     = 4,
    parameter int PERIOD    = 10,
    parameter int DUTY_INIT = 5,
    parameter int STEP      = 1,
    parameter int DB_DIV    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       inc_btn,
    input  logic [CHANNELS-1:0]       dec_btn,
    input  logic                      center_mode,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*CNT_W-1:0] duty_out,
    output logic                      period_start
);

    localparam int                 DIV_W    = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
    localparam int                 SUM_W    = CNT_W + 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DB_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]   DUTY_RST = CNT_W'(DUTY_INIT);
    localparam logic [CNT_W-1:0]   PERIOD_D = CNT_W'(PERIOD);
    localparam logic [SUM_W-1:0]   PERIOD_X = SUM_W'(PERIOD);
    localparam logic [SUM_W-1:0]   STEP_X   = SUM_W'(STEP);

    logic [DIV_W-1:0]                 div_r;
    logic                             tick_s;
    logic [CHANNELS-1:0]              inc_s1_r, inc_s2_r, dec_s1_r, dec_s2_r;
    logic [CHANNELS-1:0]              inc_press_s, dec_press_s;
    logic [CNT_W-1:0]                 cnt_r;
    logic                             boundary_s;
    logic [CHANNELS-1:0][CNT_W-1:0]   duty_tgt_r, duty_tgt_nxt_s, duty_act_r;
    logic                             mode_act_r;
    logic [CHANNELS-1:0]              pwm_nxt_s, pwm_out_r;
    logic                             period_start_r;

    assign tick_s      = (div_r == DIV_LAST);
    assign inc_press_s = {CHANNELS{tick_s}} & inc_s1_r & ~inc_s2_r;
    assign dec_press_s = {CHANNELS{tick_s}} & dec_s1_r & ~dec_s2_r;
    assign boundary_s  = (cnt_r == CNT_LAST);

    // Debounce tick divider and two-stage button samplers that only advance on ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r    <= '0;
            inc_s1_r <= '0;
            inc_s2_r <= '0;
            dec_s1_r <= '0;
            dec_s2_r <= '0;
        end else begin
            div_r <= tick_s ? '0 : div_r + DIV_W'(1'b1);
            if (tick_s) begin
                inc_s1_r <= inc_btn;
                inc_s2_r <= inc_s1_r;
                dec_s1_r <= dec_btn;
                dec_s2_r <= dec_s1_r;
            end
        end
    end

    // Saturating target duty update; one extra bit of headroom keeps the sum from wrapping.
    always_comb begin
        duty_tgt_nxt_s = duty_tgt_r;
        for (int i = 0; i < CHANNELS; i++) begin
            if (inc_press_s[i] && !dec_press_s[i]) begin
                if (({1'b0, duty_tgt_r[i]} + STEP_X) > PERIOD_X) begin
                    duty_tgt_nxt_s[i] = PERIOD_D;
                end else begin
                    duty_tgt_nxt_s[i] = duty_tgt_r[i] + STEP_X[CNT_W-1:0];
                end
            end else if (dec_press_s[i] && !inc_press_s[i]) begin
                if ({1'b0, duty_tgt_r[i]} >= STEP_X) begin
                    duty_tgt_nxt_s[i] = duty_tgt_r[i] - STEP_X[CNT_W-1:0];
                end else begin
                    duty_tgt_nxt_s[i] = '0;
                end
            end else begin
                duty_tgt_nxt_s[i] = duty_tgt_r[i];
            end
        end
    end

    // Period counter, target duty, and shadow duty/mode loaded at the last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            duty_tgt_r <= {CHANNELS{DUTY_RST}};
            duty_act_r <= {CHANNELS{DUTY_RST}};
            mode_act_r <= 1'b0;
        end else begin
            cnt_r      <= boundary_s ? '0 : cnt_r + CNT_W'(1'b1);
            duty_tgt_r <= duty_tgt_nxt_s;
            if (boundary_s) begin
                duty_act_r <= duty_tgt_r;
                mode_act_r <= center_mode;
            end
        end
    end

    // Output decode; centre mode places the high window symmetrically around mid-period.
    always_comb begin
        pwm_nxt_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            logic [SUM_W-1:0] lo_v;
            logic [SUM_W-1:0] hi_v;
            logic [SUM_W-1:0] cnt_v;
            cnt_v = {1'b0, cnt_r};
            lo_v  = (PERIOD_X - {1'b0, duty_act_r[i]}) >> 1'b1;
            hi_v  = lo_v + {1'b0, duty_act_r[i]};
            if (mode_act_r) begin
                pwm_nxt_s[i] = (cnt_v >= lo_v) && (cnt_v < hi_v);
            end else begin
                pwm_nxt_s[i] = cnt_v < {1'b0, duty_act_r[i]};
            end
        end
    end

    // Registered outputs, one cycle behind the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out_r      <= '0;
            period_start_r <= 1'b0;
        end else begin
            pwm_out_r      <= pwm_nxt_s;
            period_start_r <= (cnt_r == '0);
        end
    end

    assign pwm_out      = pwm_out_r;
    assign period_start = period_start_r;
    assign duty_out     = duty_act_r;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomised scoreboard bench for pwm_multi_ch: a cycle-indexed arithmetic reference model
// pushes expected outputs per clock, and a negedge monitor pops and compares them.
module tb_pwm_multi_ch;

    localparam int CH   = 2;
    localparam int W    = 4;
    localparam int P    = 10;
    localparam int INIT = 5;
    localparam int ST   = 1;
    localparam int D    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   inc_btn = '0;
    logic [CH-1:0]   dec_btn = '0;
    logic            center_mode = 1'b0;
    logic [CH-1:0]   pwm_out;
    logic [CH*W-1:0] duty_out;
    logic            period_start;

    pwm_multi_ch #(.CHANNELS(CH), .CNT_W(W), .PERIOD(P), .DUTY_INIT(INIT), .STEP(ST), .DB_DIV(D)) dut (
        .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn), .center_mode(center_mode),
        .pwm_out(pwm_out), .duty_out(duty_out), .period_start(period_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0]   pwm;
        logic            ps;
        logic [CH*W-1:0] duty;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: cycles since reset, target/active duty, mode, per-tick button samples.
    int              m_n = 0;
    bit              m_started = 1'b0;
    int              m_tgt[CH];
    int              m_act[CH];
    bit              m_mode;
    logic [CH-1:0]   inc_hist[$];
    logic [CH-1:0]   dec_hist[$];

    function automatic bit pattern(input int duty, input bit centre, input int pos);
        int lo;
        if (!centre) return pos < duty;
        lo = (P - duty) / 2;
        return (pos >= lo) && (pos < lo + duty);
    endfunction

    function automatic logic [CH-1:0] presses(input logic [CH-1:0] hist[$]);
        logic [CH-1:0] newest;
        logic [CH-1:0] older;
        newest = (hist.size() >= 1) ? hist[hist.size()-1] : '0;
        older  = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
        return newest & ~older;
    endfunction

    initial begin
        exp_t e;
        logic [CH-1:0] pi, pd;
        int pos;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_n = 0;
                m_mode = 1'b0;
                for (int c = 0; c < CH; c++) begin
                    m_tgt[c] = INIT;
                    m_act[c] = INIT;
                end
                inc_hist.delete();
                dec_hist.delete();
                m_started = 1'b1;
                e.pwm = '0;
                e.ps = 1'b0;
                for (int c = 0; c < CH; c++) e.duty[c*W +: W] = W'(INIT);
                exp_q.push_back(e);
            end else if (m_started) begin
                pos = m_n % P;
                for (int c = 0; c < CH; c++) e.pwm[c] = pattern(m_act[c], m_mode, pos);
                e.ps = (pos == 0);
                if (pos == P - 1) begin
                    for (int c = 0; c < CH; c++) m_act[c] = m_tgt[c];
                    m_mode = center_mode;
                end
                if (m_n % D == D - 1) begin
                    pi = presses(inc_hist);
                    pd = presses(dec_hist);
                    inc_hist.push_back(inc_btn);
                    dec_hist.push_back(dec_btn);
                    if (inc_hist.size() > 2) void'(inc_hist.pop_front());
                    if (dec_hist.size() > 2) void'(dec_hist.pop_front());
                    for (int c = 0; c < CH; c++) begin
                        if (pi[c] && !pd[c]) m_tgt[c] = (m_tgt[c] + ST > P) ? P : m_tgt[c] + ST;
                        else if (pd[c] && !pi[c]) m_tgt[c] = (m_tgt[c] < ST) ? 0 : m_tgt[c] - ST;
                    end
                end
                for (int c = 0; c < CH; c++) e.duty[c*W +: W] = W'(m_act[c]);
                exp_q.push_back(e);
                m_n++;
            end
        end
    end

    // Monitor: the DUT presents a fresh output set every cycle once the model has started.
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {pwm_out, period_start, duty_out};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL sb t=%0t: got pwm=%b ps=%b duty=%h expected pwm=%b ps=%b duty=%h",
                             $time, got.pwm, got.ps, got.duty, e.pwm, e.ps, e.duty);
                end
            end else if (m_started) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty t=%0t: got no expected entry, required one per cycle", $time);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic press(input int c, input bit up);
        if (up) inc_btn[c] = 1'b1; else dec_btn[c] = 1'b1;
        cyc(3 * D);
        if (up) inc_btn[c] = 1'b0; else dec_btn[c] = 1'b0;
        cyc(3 * D);
    endtask

    task automatic wait_pos(input int target, input string nm);
        int k;
        for (k = 0; k < 2 * P && (m_n % P) != target; k++) cyc(1);
        chk(nm, m_n % P, target);
    endtask

    function automatic int duty_of(input int c);
        return int'(duty_out[c*W +: W]);
    endfunction

    initial begin
        int v;
        cyc(3);
        rst = 1'b0;

        cyc(40);
        @(negedge clk);
        chk("init_duty0", duty_of(0), 5);
        chk("init_duty1", duty_of(1), 5);

        inc_btn[0] = 1'b1;
        cyc(8);
        inc_btn[0] = 1'b0;
        cyc(2 * P + 4);
        @(negedge clk);
        chk("one_press_ch0", duty_of(0), 6);
        chk("one_press_ch1", duty_of(1), 5);

        repeat (7) press(0, 1'b1);
        cyc(2 * P + 2);
        @(negedge clk);
        chk("sat_high", duty_of(0), 10);
        repeat (12) press(0, 1'b0);
        cyc(2 * P + 2);
        @(negedge clk);
        chk("sat_low", duty_of(0), 0);

        inc_btn[1] = 1'b1;
        dec_btn[1] = 1'b1;
        cyc(3 * D);
        inc_btn[1] = 1'b0;
        dec_btn[1] = 1'b0;
        cyc(3 * D + 2 * P);
        @(negedge clk);
        chk("inc_dec_same", duty_of(1), 5);
        inc_btn[1] = 1'b1; cyc(1);
        inc_btn[1] = 1'b0; cyc(1);
        inc_btn[1] = 1'b1; cyc(1);
        inc_btn[1] = 1'b0;
        cyc(3 * D + 2 * P);
        @(negedge clk);
        v = duty_of(1);
        chk("bounce_one_event", int'(v == 5 || v == 6), 1);

        repeat (4) press(0, 1'b1);
        cyc(2 * P);
        @(negedge clk);
        chk("duty4", duty_of(0), 4);
        cyc(1);
        wait_pos(5, "reach_mid");
        center_mode = 1'b1;
        v = 0;
        for (int k = 0; k < 3 * P && v == 0; k++) begin
            @(negedge clk);
            if (period_start) v = 1;
        end
        chk("ps_seen", v, 1);
        for (int k = 0; k < P; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("centre_pos%0d", k), int'(pwm_out[0]), int'(k >= 3 && k <= 6));
        end

        center_mode = 1'b0;
        cyc(1);
        repeat (4) press(0, 1'b1);
        cyc(2 * P + 2);
        @(negedge clk);
        chk("duty8", duty_of(0), 8);
        cyc(1);
        wait_pos(3, "reach_cnt3");
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_ps", int'(period_start), 0);
        chk("rst_duty0", duty_of(0), 5);
        chk("rst_duty1", duty_of(1), 5);
        @(negedge clk);
        chk("rst_restart_ps", int'(period_start), 1);

        cyc(1);
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(7) == 0) inc_btn[c] = ~inc_btn[c];
                if ($urandom_range(7) == 0) dec_btn[c] = ~dec_btn[c];
            end
            if ($urandom_range(39) == 0) center_mode = ~center_mode;
            rst = ($urandom_range(399) == 0);
            cyc(1);
        end
        rst = 1'b0;
        inc_btn = '0;
        dec_btn = '0;
        cyc(5);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
